pio_pti: RTL and testbench
==========================

Name: pio_pti

Overview:
- Pulse-train input (PTI) capture block: the receive-side counterpart of the servo pulse-train output peripheral.
- Samples an external step/direction pulse stream, such as servo driver feedback or a loop-back of the PTO output.
- Keeps a signed position count, a total pulse count and the last pulse period in microseconds, and detects stall and target-reached.
- Exposed to Nios II as an Avalon-MM slave with a level interrupt.

Parameters:
- CLK_PER_US, 50, clk cycles per microsecond tick (≥2).
- FILTER_LEN, 4, consecutive stable synchronized samples needed to accept a level change on pulse_in/dir_in (1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  8  register index.
- chipselect  in  1  slave select.
- write  in  1  write strobe.
- read  in  1  read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- irq  out  1  interrupt, level, active-high.
- pulse_in  in  1  asynchronous step input; rising edge = one step.
- dir_in  in  1  asynchronous direction input; 1 = count up, 0 = count down.

Behaviour:
- Reset: all registers 0, readdata=0, irq=0, FSM=IDLE.
- Register map (word addresses):
  - 0 CTRL rw: bit0 enable, bit1 clear (write-only, self-clearing, reads 0), bit2 irq_en.
  - 1 STATUS r/W1C: bit0 target_hit, bit1 period_valid (read-only), bit2 stalled, bit3 overflow.
  - 2 POSITION rw, signed.
  - 3 PERIOD_US r.
  - 4 TARGET rw.
  - 5 TIMEOUT_US rw.
  - 6 PULSE_TOTAL r.
  - Unmapped addresses: write ignored, read returns 0.
- Bus timing:
  - Write takes effect on the clk edge of chipselect&write.
  - Read: readdata valid 1 cycle after chipselect&read.
  - readdata returns 0 in any cycle without chipselect&read.
  - write has priority if both read and write are asserted.
- Input path: 2-FF synchronizer per input, then glitch filter (FILTER_LEN), then rising-edge detect on filtered pulse.
  - Latency from a pulse_in rise to POSITION update: 2+FILTER_LEN+1 clk.
  - dir is sampled from the filtered dir_in in the edge cycle.
- Count (only when enable=1):
  - On a step, POSITION ±1 (two's-complement wrap) and PULSE_TOTAL +1 (saturates at 0xFFFFFFFF).
  - Wrap 0x7FFFFFFF→0x80000000 or the reverse sets overflow.
- Target: target_hit is set when the post-update POSITION equals TARGET following a step. It is sticky.
- irq = irq_en & (target_hit | stalled), registered, 1 cycle after the status bit sets.
- Microsecond tick:
  - Prescaler counts 0..CLK_PER_US-1 and pulses us_tick on the wrap.
  - Prescaler runs only while enable=1; it is reset when enable=0.
- Period FSM:
  - IDLE: enable=0. Edge counter held at 0.
  - IDLE→WAIT_FIRST: on enable=1.
  - WAIT_FIRST→MEASURE: on the first step. Edge counter cleared; no period captured.
  - MEASURE, on a step: PERIOD_US ← edge counter (saturating 32-bit us count), period_valid=1, counter←0.
  - MEASURE→STALLED: when the counter reaches TIMEOUT_US while TIMEOUT_US≠0. Sets stalled, clears period_valid.
  - STALLED→MEASURE: on the next step. Counter←0; the next full interval gives a valid period.
  - Any state→IDLE: when enable=0. PERIOD_US is kept, period_valid cleared.
  - TIMEOUT_US=0 disables stall detection.
- clear=1: in one cycle, zeroes POSITION, PULSE_TOTAL, PERIOD_US and all STATUS bits, and sends the FSM to WAIT_FIRST if enabled.
- Collisions:
  - Bus write to POSITION in the same cycle as a step: the write wins; the step is dropped.
  - W1C in the same cycle as a new set event: the set wins.
  - clear wins over every event.
- Mid-operation reset_n assertion: immediate return to reset values; synchronizers flushed.

Optional Feature:
- Macro PTI_QUAD_DECODE_EN.
- When defined: pulse_in/dir_in are treated as quadrature A/B with x4 decoding.
  - Every valid filtered A or B transition counts ±1; A leading B counts up.
  - An illegal double transition (both change in one cycle) sets STATUS bit4 quad_err and does not count.
  - Period is measured between consecutive counted transitions.
- When undefined: step/direction mode as above; STATUS bit4 reads 0.

Test Plan:
- Reset; write CTRL=1; 10 pulse_in rises with dir_in=1, each 20 µs apart (CLK_PER_US=50) → POSITION=10, PULSE_TOTAL=10, PERIOD_US=20, period_valid=1.
- POSITION=0, TARGET=-3, CTRL=5; 3 pulses with dir_in=0 → target_hit=1 and irq=1. Write STATUS=1 → irq=0 on the next cycle.
- TIMEOUT_US=100; 2 pulses then idle for 150 µs → stalled=1 at 100 µs after the last edge, period_valid=0, irq=1 (irq_en=1). The next two pulses 30 µs apart → PERIOD_US=30.
- Write POSITION=0x7FFFFFFF; 1 pulse up → POSITION=0x80000000, overflow=1. Pulse in the same cycle as a POSITION write of 5 → POSITION=5.
- pulse_in glitch of FILTER_LEN-1 cycles → no count. Read of address 9 → readdata=0. Write CTRL=3 → counters zero, CTRL reads back 1.
- PTI_QUAD_DECODE_EN: one full A-leads-B quadrature cycle → POSITION=+4. A and B toggling together → quad_err=1, POSITION unchanged.

Source files
------------

// File: rtl/pio_pti_if.sv
// pio_pti_if: Avalon-MM slave bus bundle for the pulse-train input capture block.
interface pio_pti_if;
  logic [7:0]  address;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, read, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, read, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_pti.sv
// pio_pti: pulse-train input capture. Counts step/dir pulses into a signed
// position, tracks total pulses and the last pulse period in microseconds,
// and flags stall / target-reached. Define PTI_QUAD_DECODE_EN to treat
// pulse_in/dir_in as quadrature A/B with x4 decoding instead of step/dir.
module pio_pti #(
  parameter int unsigned CLK_PER_US = 50,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  pio_pti_if.slave bus,
  output logic     irq,
  input  logic     pulse_in,
  input  logic     dir_in
);
  localparam int unsigned PW = $clog2(CLK_PER_US);
  localparam int unsigned FW = 4;
`ifdef PTI_QUAD_DECODE_EN
  localparam int unsigned QW = 2;
`else
  localparam int unsigned QW = 1;
`endif
  localparam logic [7:0] A_CTRL    = 8'd0;
  localparam logic [7:0] A_STATUS  = 8'd1;
  localparam logic [7:0] A_POS     = 8'd2;
  localparam logic [7:0] A_PERIOD  = 8'd3;
  localparam logic [7:0] A_TARGET  = 8'd4;
  localparam logic [7:0] A_TIMEOUT = 8'd5;
  localparam logic [7:0] A_TOTAL   = 8'd6;

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, STALLED} state_t;
  state_t state;

  // index 0 = pulse_in (A), index 1 = dir_in (B)
  logic [1:0]    sync1, sync2, flt;
  logic [FW-1:0] fcnt [2];
  logic [QW-1:0] flt_q;

  logic          ctrl_en, ctrl_irq_en;
  logic [31:0]   position, period_us, target, timeout_us, pulse_total, edge_cnt;
  logic          target_hit, period_valid, stalled, overflow, quad_err;
  logic [PW-1:0] presc;

  logic          wr_c, rd_c, wr_ctrl_c, wr_stat_c, wr_pos_c, clr_c;
  logic          step_c, up_c, qerr_c, step_ok_c, qerr_ok_c, us_tick_c, ovf_c;
  logic [4:0]    w1c_c;
  logic [31:0]   pos_step_c, edge_inc_c, rd_mux_c;

  assign wr_c       = bus.chipselect & bus.write;
  assign rd_c       = bus.chipselect & bus.read & ~bus.write;
  assign wr_ctrl_c  = wr_c & (bus.address == A_CTRL);
  assign wr_stat_c  = wr_c & (bus.address == A_STATUS);
  assign wr_pos_c   = wr_c & (bus.address == A_POS);
  assign clr_c      = wr_ctrl_c & bus.writedata[1];
  assign w1c_c      = wr_stat_c ? bus.writedata[4:0] : 5'd0;

`ifdef PTI_QUAD_DECODE_EN
  // x4 decode: exactly one channel changing is a count, both changing is illegal
  assign step_c = (flt[0] ^ flt_q[0]) ^ (flt[1] ^ flt_q[1]);
  assign up_c   = (flt[0] ^ flt_q[0]) ? (flt[0] != flt[1]) : (flt[1] == flt[0]);
  assign qerr_c = (flt[0] ^ flt_q[0]) & (flt[1] ^ flt_q[1]);
`else
  // step/dir: rising edge of filtered pulse, direction from filtered dir
  assign step_c = flt[0] & ~flt_q[0];
  assign up_c   = flt[1];
  assign qerr_c = 1'b0;
`endif

  assign step_ok_c  = step_c & ctrl_en & ~wr_pos_c & ~clr_c;
  assign qerr_ok_c  = qerr_c & ctrl_en & ~clr_c;
  assign pos_step_c = up_c ? position + 32'd1 : position - 32'd1;
  assign ovf_c      = up_c ? (position == 32'h7FFF_FFFF) : (position == 32'h8000_0000);
  assign us_tick_c  = ctrl_en & (presc == PW'(CLK_PER_US - 1));
  assign edge_inc_c = (us_tick_c && edge_cnt != '1) ? edge_cnt + 32'd1 : edge_cnt;

  // Register read mux
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      A_CTRL:    rd_mux_c = {29'd0, ctrl_irq_en, 1'b0, ctrl_en};
      A_STATUS:  rd_mux_c = {27'd0, quad_err, overflow, stalled, period_valid, target_hit};
      A_POS:     rd_mux_c = position;
      A_PERIOD:  rd_mux_c = period_us;
      A_TARGET:  rd_mux_c = target;
      A_TIMEOUT: rd_mux_c = timeout_us;
      A_TOTAL:   rd_mux_c = pulse_total;
      default:   rd_mux_c = '0;
    endcase
  end

  // Two-flop synchronizers and previous filtered level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      flt_q <= '0;
    end else begin
      sync1 <= {dir_in, pulse_in};
      sync2 <= sync1;
      flt_q <= flt[QW-1:0];
    end
  end

  // Glitch filter: accept a level only after FILTER_LEN stable samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt     <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          fcnt[i] <= '0;
          flt[i]  <= sync2[i];
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Control, counters, sticky status, interrupt and bus read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en      <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      target       <= '0;
      timeout_us   <= '0;
      position     <= '0;
      pulse_total  <= '0;
      target_hit   <= 1'b0;
      overflow     <= 1'b0;
      quad_err     <= 1'b0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (wr_ctrl_c) begin
        ctrl_en     <= bus.writedata[0];
        ctrl_irq_en <= bus.writedata[2];
      end
      if (wr_c && bus.address == A_TARGET)  target     <= bus.writedata;
      if (wr_c && bus.address == A_TIMEOUT) timeout_us <= bus.writedata;
      if (clr_c) begin
        position    <= '0;
        pulse_total <= '0;
        target_hit  <= 1'b0;
        overflow    <= 1'b0;
        quad_err    <= 1'b0;
      end else begin
        if (wr_pos_c)       position <= bus.writedata;
        else if (step_ok_c) position <= pos_step_c;
        if (step_ok_c && pulse_total != '1) pulse_total <= pulse_total + 32'd1;
        if (step_ok_c && pos_step_c == target) target_hit <= 1'b1;
        else if (w1c_c[0])                     target_hit <= 1'b0;
        if (step_ok_c && ovf_c) overflow <= 1'b1;
        else if (w1c_c[3])      overflow <= 1'b0;
        if (qerr_ok_c)          quad_err <= 1'b1;
        else if (w1c_c[4])      quad_err <= 1'b0;
      end
      irq          <= ctrl_irq_en & (target_hit | stalled);
      bus.readdata <= rd_c ? rd_mux_c : '0;
    end
  end

  // Microsecond prescaler and period/stall FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      state        <= IDLE;
      edge_cnt     <= '0;
      period_us    <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      presc <= (!ctrl_en || us_tick_c) ? '0 : presc + PW'(1);
      if (clr_c) begin
        period_us    <= '0;
        period_valid <= 1'b0;
        stalled      <= 1'b0;
        edge_cnt     <= '0;
        state        <= bus.writedata[0] ? WAIT_FIRST : IDLE;
      end else begin
        if (w1c_c[2]) stalled <= 1'b0;
        case (state)
          IDLE: begin
            edge_cnt     <= '0;
            period_valid <= 1'b0;
            if (ctrl_en) state <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            edge_cnt <= '0;
            if (step_ok_c) state <= MEASURE;
          end
          MEASURE: begin
            if (step_ok_c) begin
              period_us    <= edge_inc_c;
              period_valid <= 1'b1;
              edge_cnt     <= '0;
            end else begin
              edge_cnt <= edge_inc_c;
              if (timeout_us != '0 && edge_inc_c >= timeout_us) begin
                state        <= STALLED;
                stalled      <= 1'b1;
                period_valid <= 1'b0;
              end
            end
          end
          STALLED: begin
            if (step_ok_c) begin
              state    <= MEASURE;
              edge_cnt <= '0;
            end else begin
              edge_cnt <= edge_inc_c;
            end
          end
          default: state <= IDLE;
        endcase
        if (!ctrl_en) begin
          state        <= IDLE;
          period_valid <= 1'b0;
          edge_cnt     <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pio_pti.sv
// tb_pio_pti: self-checking bench for pio_pti with a behavioural position/period model.
`timescale 1ns/1ps
module tb_pio_pti;
  localparam int unsigned CPU = 50;
  localparam int unsigned FL  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pulse_in = 1'b0;
  logic dir_in = 1'b0;
  logic irq;

  pio_pti_if bus();

  pio_pti #(.CLK_PER_US(CPU), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq),
    .pulse_in(pulse_in), .dir_in(dir_in)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_pos, m_total, rd;
  logic        m_en;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  // One step with direction d; next rise follows gap_us microseconds after this rise
  task automatic pulse_at(input logic d, input int unsigned gap_us);
    dir_in = d;
    cycles(20);
    pulse_in = 1'b1;
    cycles(10);
    pulse_in = 1'b0;
    cycles(int'(gap_us * CPU) - 30);
    if (m_en) begin
      m_pos = d ? m_pos + 32'd1 : m_pos - 32'd1;
      if (m_total != '1) m_total = m_total + 32'd1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    n_checks++;
    if (bus.readdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: readdata=%h irq=%b, want 0/0", bus.readdata, irq);
    end
    reset_n = 1'b1;
    cycles(2);
    for (int a = 0; a < 7; a++) begin
      bus_read(8'(a), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h, want 0", a, rd);
      end
    end
    m_pos = '0; m_total = '0; m_en = 1'b0;
  endtask

  task automatic test_count();
    bus_write(8'd0, 32'd1);
    m_en = 1'b1;
    for (int i = 0; i < 10; i++) pulse_at(1'b1, 20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'd10) begin n_fail++; $display("FAIL count_pos: got %h, want %h", rd, 32'd10); end
    bus_read(8'd6, rd); n_checks++;
    if (rd !== 32'd10) begin n_fail++; $display("FAIL count_total: got %h, want %h", rd, 32'd10); end
    bus_read(8'd3, rd); n_checks++;
    if (rd !== 32'd20) begin n_fail++; $display("FAIL count_period: got %0d, want 20", rd); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[1] !== 1'b1) begin n_fail++; $display("FAIL count_pvalid: got %b, want 1", rd[1]); end
  endtask

  task automatic test_random();
    int unsigned n, g, exp_period;
    logic d;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(3, 6);
      exp_period = 0;
      for (int unsigned i = 0; i < n; i++) begin
        d = 1'($urandom_range(0, 1));
        g = $urandom_range(5, 20);
        if (i == n - 2) exp_period = g;
        pulse_at(d, g);
      end
      bus_read(8'd2, rd); n_checks++;
      if (rd !== m_pos) begin n_fail++; $display("FAIL rand%0d_pos: got %h, want %h", r, rd, m_pos); end
      bus_read(8'd6, rd); n_checks++;
      if (rd !== m_total) begin n_fail++; $display("FAIL rand%0d_total: got %h, want %h", r, rd, m_total); end
      bus_read(8'd3, rd); n_checks++;
      if (rd !== exp_period) begin n_fail++; $display("FAIL rand%0d_period: got %0d, want %0d", r, rd, exp_period); end
    end
  endtask

  task automatic test_target();
    bus_write(8'd2, 32'd0); m_pos = '0;
    bus_write(8'd4, 32'hFFFF_FFFD);
    bus_write(8'd1, 32'h1F);
    bus_write(8'd0, 32'd5);
    pulse_at(1'b0, 20);
    pulse_at(1'b0, 20);
    bus_read(8'd1, rd); n_checks++;
    if (rd[0] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL target_early: hit=%b irq=%b, want 0/0", rd[0], irq);
    end
    pulse_at(1'b0, 20);
    bus_read(8'd1, rd); n_checks++;
    if (rd[0] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL target_hit: hit=%b irq=%b, want 1/1", rd[0], irq);
    end
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL target_pos: got %h, want %h", rd, m_pos); end
    bus_write(8'd1, 32'd1);
    cycles(1); n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL target_irq_clear: irq=%b, want 0", irq); end
  endtask

  task automatic test_stall();
    bus_write(8'd5, 32'd100);
    bus_write(8'd1, 32'h1F);
    pulse_at(1'b1, 20);
    pulse_at(1'b1, 95);
    bus_read(8'd1, rd); n_checks++;
    if (rd[2] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL stall_early: stalled=%b irq=%b, want 0/0", rd[2], irq);
    end
    cycles(350);
    bus_read(8'd1, rd); n_checks++;
    if (rd[2] !== 1'b1 || rd[1] !== 1'b0 || irq !== 1'b1) begin
      n_fail++; $display("FAIL stall_set: stalled=%b pvalid=%b irq=%b, want 1/0/1", rd[2], rd[1], irq);
    end
    pulse_at(1'b1, 30);
    pulse_at(1'b1, 30);
    bus_read(8'd3, rd); n_checks++;
    if (rd !== 32'd30) begin n_fail++; $display("FAIL stall_recover_period: got %0d, want 30", rd); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[1] !== 1'b1) begin n_fail++; $display("FAIL stall_recover_pvalid: got %b, want 1", rd[1]); end
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL stall_pos: got %h, want %h", rd, m_pos); end
    bus_write(8'd5, 32'd0);
    bus_write(8'd1, 32'h1F);
  endtask

  task automatic test_overflow();
    bus_write(8'd2, 32'h7FFF_FFFF); m_pos = 32'h7FFF_FFFF;
    pulse_at(1'b1, 20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_pos: got %h, want 80000000", rd); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, want 1", rd[3]); end
    // Step lands on the same edge as a POSITION write: the write wins
    dir_in = 1'b1;
    cycles(20);
    pulse_in = 1'b1;
    cycles(5);
    bus_write(8'd2, 32'd5);
    m_pos = 32'd5;
    cycles(5);
    pulse_in = 1'b0;
    cycles(20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'd5) begin n_fail++; $display("FAIL collide_pos: got %h, want 5", rd); end
    bus_read(8'd6, rd); n_checks++;
    if (rd !== m_total) begin n_fail++; $display("FAIL collide_total: got %h, want %h", rd, m_total); end
  endtask

  task automatic test_misc();
    dir_in = 1'b1;
    cycles(5);
    pulse_in = 1'b1; cycles(FL - 1); pulse_in = 1'b0; cycles(20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL glitch_short: got %h, want %h", rd, m_pos); end
    pulse_in = 1'b1; cycles(FL); pulse_in = 1'b0; cycles(20);
    m_pos = m_pos + 32'd1; m_total = m_total + 32'd1;
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL glitch_exact: got %h, want %h", rd, m_pos); end
    bus_read(8'd9, rd); n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h, want 0", rd); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[4] !== 1'b0) begin n_fail++; $display("FAIL quad_err_bit: got %b, want 0", rd[4]); end
    cycles(1); n_checks++;
    if (bus.readdata !== 32'd0) begin n_fail++; $display("FAIL idle_readdata: got %h, want 0", bus.readdata); end
    bus_write(8'd0, 32'd3);
    m_pos = '0; m_total = '0;
    for (int a = 1; a < 7; a++) begin
      if (a == 4 || a == 5) continue;
      bus_read(8'(a), rd); n_checks++;
      if (rd !== 32'd0) begin n_fail++; $display("FAIL clear_reg%0d: got %h, want 0", a, rd); end
    end
    bus_read(8'd0, rd); n_checks++;
    if (rd !== 32'd1) begin n_fail++; $display("FAIL clear_ctrl: got %h, want 1", rd); end
    pulse_at(1'b1, 20);
    pulse_at(1'b1, 20);
    bus_read(8'd3, rd); n_checks++;
    if (rd !== 32'd20) begin n_fail++; $display("FAIL clear_first_period: got %0d, want 20", rd); end
    bus_write(8'd0, 32'd0); m_en = 1'b0;
    pulse_at(1'b1, 20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL disabled_pos: got %h, want %h", rd, m_pos); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[1] !== 1'b0) begin n_fail++; $display("FAIL disabled_pvalid: got %b, want 0", rd[1]); end
    bus_read(8'd3, rd); n_checks++;
    if (rd !== 32'd20) begin n_fail++; $display("FAIL disabled_period_kept: got %0d, want 20", rd); end
  endtask

  function automatic int gidx(input logic a, input logic b);
    return a ? (b ? 2 : 1) : (b ? 3 : 0);
  endfunction

  task automatic test_quad();
    logic a, b, na, nb;
    int   dlt;
    bus_write(8'd0, 32'd3);
    m_pos = '0;
    pulse_in = 1'b1; dir_in = 1'b0; cycles(20);
    pulse_in = 1'b1; dir_in = 1'b1; cycles(20);
    pulse_in = 1'b0; dir_in = 1'b1; cycles(20);
    pulse_in = 1'b0; dir_in = 1'b0; cycles(20);
    m_pos = 32'd4;
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'd4) begin n_fail++; $display("FAIL quad_cycle_pos: got %h, want 4", rd); end
    pulse_in = 1'b1; dir_in = 1'b1; cycles(20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'd4) begin n_fail++; $display("FAIL quad_err_pos: got %h, want 4", rd); end
    bus_read(8'd1, rd); n_checks++;
    if (rd[4] !== 1'b1) begin n_fail++; $display("FAIL quad_err_flag: got %b, want 1", rd[4]); end
    a = 1'b1; b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      na = 1'($urandom_range(0, 1));
      nb = 1'($urandom_range(0, 1));
      dlt = (gidx(na, nb) - gidx(a, b) + 4) % 4;
      if (dlt == 1) m_pos = m_pos + 32'd1;
      else if (dlt == 3) m_pos = m_pos - 32'd1;
      pulse_in = na; dir_in = nb; a = na; b = nb;
      cycles(20);
    end
    bus_read(8'd2, rd); n_checks++;
    if (rd !== m_pos) begin n_fail++; $display("FAIL quad_walk_pos: got %h, want %h", rd, m_pos); end
    pulse_in = 1'b0; dir_in = 1'b0;
    bus_write(8'd0, 32'd0);
    cycles(20);
  endtask

  task automatic test_mid_reset();
    bus_write(8'd0, 32'd1);
    bus_write(8'd2, 32'h1234_5678);
    pulse_in = 1'b1; dir_in = 1'b1;
    cycles(3);
    reset_n = 1'b0;
    cycles(1); n_checks++;
    if (bus.readdata !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out: readdata=%h irq=%b, want 0/0", bus.readdata, irq);
    end
    pulse_in = 1'b0; dir_in = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(20);
    bus_read(8'd2, rd); n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_pos: got %h, want 0", rd); end
    bus_read(8'd0, rd); n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_ctrl: got %h, want 0", rd); end
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write = 1'b0;
    bus.read = 1'b0; bus.writedata = '0;
    test_reset();
`ifdef PTI_QUAD_DECODE_EN
    test_quad();
`else
    test_count();
    test_random();
    test_target();
    test_stall();
    test_overflow();
    test_misc();
`endif
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
